// File: rtl/mul_shift_seq.sv
// Multiply/shift sequencer: free-running pulse-interval counter with
// minor-cycle parity, plus the order control that drives c5/c6/c7/s2.
module mul_shift_seq #(
    parameter int PI_PER_MC  = 36,
    parameter int MUL_DIGITS = 17,
    parameter int SHIFT_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_mul,
    input  logic               start_shift,
    input  logic [SHIFT_W-1:0] shift_places,
    output logic               d0,
    output logic               d35,
    output logic               ev_d0,
    output logic               c5,
    output logic               c6,
    output logic               s2,
    output logic               c7,
    output logic               busy,
    output logic               done
);

    localparam int PI_W  = $clog2(PI_PER_MC);
    localparam int MD_W  = $clog2(MUL_DIGITS + 1);
    localparam int CNT_W = (SHIFT_W > MD_W) ? SHIFT_W : MD_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MUL,
        S_SHIFT,
        S_FINISH
    } state_t;

    logic [PI_W-1:0]    pi_q, pi_d;
    logic               mc_odd_q, mc_odd_d;
    state_t             state_q, state_d;
    logic               op_shift_q, op_shift_d;
    logic [SHIFT_W-1:0] places_q, places_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic end_mc;
    logic pi_zero;

    assign end_mc  = (pi_q == PI_W'(PI_PER_MC - 1));
    assign pi_zero = (pi_q == '0);

    always_comb begin
        pi_d     = end_mc ? '0 : pi_q + PI_W'(1);
        mc_odd_d = mc_odd_q ^ end_mc;
    end

    always_comb begin
        state_d    = state_q;
        op_shift_d = op_shift_q;
        places_d   = places_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_mul) begin
                    state_d    = S_ARM;
                    op_shift_d = 1'b0;
                end else if (start_shift) begin
                    state_d    = S_ARM;
                    op_shift_d = 1'b1;
                    places_d   = shift_places;
                end
            end
            // Orders always begin on the d0 of an even minor cycle
            S_ARM: begin
                if (end_mc && mc_odd_q) begin
                    if (!op_shift_q) begin
                        cnt_d   = CNT_W'(MUL_DIGITS);
                        state_d = S_MUL;
                    end else if (places_q != '0) begin
                        cnt_d   = CNT_W'(places_q);
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_MUL, S_SHIFT: begin
                if (end_mc) begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_FINISH;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_FINISH: begin
                if (end_mc) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pi_q       <= '0;
            mc_odd_q   <= 1'b0;
            state_q    <= S_IDLE;
            op_shift_q <= 1'b0;
            places_q   <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            pi_q       <= pi_d;
            mc_odd_q   <= mc_odd_d;
            state_q    <= state_d;
            op_shift_q <= op_shift_d;
            places_q   <= places_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    // Every output is held low for as long as reset is asserted
    assign d0    = ~rst & pi_zero;
    assign d35   = ~rst & end_mc;
    assign ev_d0 = ~rst & pi_zero & ~mc_odd_q;
    assign c5    = ~rst & (state_q == S_MUL);
    assign c6    = ~rst & (state_q == S_SHIFT);
    assign s2    = ~rst & (state_q == S_SHIFT) & pi_zero;
    assign c7    = ~rst & (state_q == S_FINISH);
    assign busy  = ~rst & (state_q != S_IDLE);
    assign done  = ~rst & done_q;

endmodule

// File: tb/tb_mul_shift_seq.sv
// Bench for mul_shift_seq: directed and random orders against a
// schedule-based model of when each order runs.
module tb_mul_shift_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_mul = 1'b0;
    logic       start_shift = 1'b0;
    logic [5:0] shift_places = '0;
    logic       d0, d35, ev_d0, c5, c6, s2, c7, busy, done;

    mul_shift_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_mul   (start_mul),
        .start_shift (start_shift),
        .shift_places(shift_places),
        .d0          (d0),
        .d35         (d35),
        .ev_d0       (ev_d0),
        .c5          (c5),
        .c6          (c6),
        .s2          (s2),
        .c7          (c7),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    wire [8:0] obs = {d0, d35, ev_d0, c5, c6, s2, c7, busy, done};

    int vec = 0;
    int err = 0;
    int t   = 0;
    int st  = 0;
    logic [8:0] got, exp_v;

    // Accepted orders since last reset: start clock, shift flag, M/C count
    int   o_ts [64];
    int   o_n  [64];
    bit   o_sh [64];
    int   n_ord = 0;

    function automatic logic [8:0] model(input int tt);
        logic [8:0] v;
        int pi, os, fe, dc;
        v    = '0;
        pi   = tt % 36;
        v[8] = (pi == 0);
        v[7] = (pi == 35);
        v[6] = (pi == 0) && (((tt / 36) % 2) == 0);
        for (int i = 0; i < n_ord; i++) begin
            os = ((o_ts[i] + 1) / 72 + 1) * 72;
            fe = os + 36 * o_n[i];
            dc = fe + 36;
            if (tt >= os && tt < fe) begin
                if (o_sh[i]) begin
                    v[4] = 1'b1;
                    if (pi == 0) v[3] = 1'b1;
                end else begin
                    v[5] = 1'b1;
                end
            end
            if (tt >= fe && tt < dc) v[2] = 1'b1;
            if (tt > o_ts[i] && tt < dc) v[1] = 1'b1;
            if (tt == dc) v[0] = 1'b1;
        end
        return v;
    endfunction

    // One clock: apply inputs, record accepted order, sample at negedge
    task automatic cyc(input logic sm, input logic ss,
                       input logic [5:0] pl, input logic r);
        rst          = r;
        start_mul    = sm;
        start_shift  = ss;
        shift_places = pl;
        if (r) begin
            n_ord = 0;
        end else if ((sm || ss) && !model(t)[1] && n_ord < 64) begin
            o_ts[n_ord] = t;
            o_sh[n_ord] = !sm;
            o_n[n_ord]  = sm ? 17 : int'(pl);
            n_ord++;
        end
        @(negedge clk);
        got   = obs;
        exp_v = r ? 9'b0 : model(t);
        st    = t;
        @(posedge clk);
        #1;
        t = r ? 0 : t + 1;
        start_mul   = 1'b0;
        start_shift = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 6'd3, 1'b1);
            vec++;
            if (got !== exp_v) begin
                err++;
                $display("FAIL reset t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_idle_timing();
        for (int k = 0; k < 80; k++) begin
            cyc(1'b0, 1'b0, 6'd0, 1'b0);
            vec++;
            if (got !== exp_v) begin
                err++;
                $display("FAIL idle t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_mul();
        cyc(1'b0, 1'b0, 6'd0, 1'b1);
        for (int k = 0; k < 730; k++) begin
            cyc(t == 5, 1'b0, 6'd0, 1'b0);
            vec++;
            if (got !== exp_v) begin
                err++;
                $display("FAIL mul t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_shift3();
        cyc(1'b0, 1'b0, 6'd0, 1'b1);
        for (int k = 0; k < 230; k++) begin
            cyc(1'b0, t == 10, 6'd3, 1'b0);
            vec++;
            if (got !== exp_v) begin
                err++;
                $display("FAIL shift3 t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_shift0();
        cyc(1'b0, 1'b0, 6'd0, 1'b1);
        for (int k = 0; k < 120; k++) begin
            cyc(1'b0, t == 40, 6'd0, 1'b0);
            vec++;
            if (got !== exp_v) begin
                err++;
                $display("FAIL shift0 t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_priority();
        cyc(1'b0, 1'b0, 6'd0, 1'b1);
        for (int k = 0; k < 730; k++) begin
            cyc(t == 5, t == 5 || t == 300, (t == 5) ? 6'd7 : 6'd2, 1'b0);
            vec++;
            if (got !== exp_v || c6 !== 1'b0) begin
                err++;
                $display("FAIL priority t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b0, 6'd0, 1'b1);
        for (int k = 0; k < 1032; k++) begin
            cyc(t == 5, 1'b0, 6'd0, k == 300);
            vec++;
            if (got !== exp_v) begin
                err++;
                $display("FAIL reset_mid t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b0, 1'b0, 6'd0, 1'b1);
        for (int k = 0; k < 900; k++) begin
            cyc(t == 144, t == 3, 6'd1, 1'b0);
            vec++;
            if (got !== exp_v) begin
                err++;
                $display("FAIL back_to_back t=%0d got=%b exp=%b", st, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            cyc(1'b0, 1'b0, 6'd0, 1'b1);
            for (int k = 0; k < 1500; k++) begin
                int r;
                logic sm, ss, rr;
                logic [5:0] pl;
                r  = int'($urandom_range(0, 99));
                sm = (r == 0) || (r == 2);
                ss = (r == 1) || (r == 2) || ((t % 72) == 71 && r < 20);
                rr = (r == 99) && (k > 700) && (k < 760);
                pl = 6'($urandom_range(0, 7));
                cyc(sm, ss, pl, rr);
                vec++;
                if (got !== exp_v) begin
                    err++;
                    $display("FAIL random t=%0d got=%b exp=%b", st, got, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_timing();
        test_mul();
        test_shift3();
        test_shift0();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/mul_shift_seq.md
Name: mul_shift_seq

Overview:
- Sequencer for the multiply/shift section of the arithmetic unit. It drives the order-timing lines c5, c6, c7 and the shift stimulus s2 consumed by ccu_2.
- Contains the local pulse-interval (p.i.) counter and minor-cycle (M/C) parity. From these it derives the d0, d35 and ev_d0 digit pulses.
- The main control accepts a multiply or shift order, runs it for the required number of minor cycles, then runs one sign/clear minor cycle and reports done.

Parameters:
- PI_PER_MC, 36, pulse intervals per minor cycle (clock periods).
- MUL_DIGITS, 17, minor cycles a multiply runs (one multiplier digit per M/C).
- SHIFT_W, 6, width of the shift place count.

Ports:
- clk  input  1  system clock, one tick = one pulse interval
- rst  input  1  synchronous, active-high reset
- start_mul  input  1  request multiply order; sampled only in IDLE
- start_shift  input  1  request shift order; sampled only in IDLE
- shift_places  input  SHIFT_W  number of places to shift; captured with start_shift
- d0  output  1  high when p.i. counter = 0
- d35  output  1  high when p.i. counter = PI_PER_MC-1
- ev_d0  output  1  d0 of an even minor cycle
- c5  output  1  multiply in progress
- c6  output  1  shift in progress
- s2  output  1  shift stimulus, one clock per shift M/C
- c7  output  1  sign/clear minor cycle
- busy  output  1  state != IDLE
- done  output  1  one-clock completion pulse

Behaviour:
Reset:
- rst is synchronous, active-high; it wins over every other input.
- Reset clears: p.i. counter = 0, mc_odd = 0, state = IDLE, order counter = 0.
- All outputs are 0 while rst is high, including d0 (forced low).
- Reset mid-operation abandons the order with no done pulse.

Timing:
- The p.i. counter runs freely from the first clock after reset release.
- Count sequence is 0..PI_PER_MC-1, then wraps to 0.
- mc_odd toggles on each wrap. The first M/C after reset is even.
- d0, d35 and ev_d0 = d0 & ~mc_odd are combinational decodes of the registered counter.
- "End of M/C" is the cycle where d35 = 1.

States:
- IDLE
  - On start_mul, go to ARM with op = MUL. start_mul has priority if both starts are high; start_shift is then ignored.
  - On start_shift alone, go to ARM with op = SHIFT and latch shift_places.
  - Starts asserted while not in IDLE are ignored. Starts are not queued.
- ARM
  - Wait until end of an odd M/C, so the order starts on ev_d0.
  - At that edge:
    - MUL: load count = MUL_DIGITS, go to MUL.
    - SHIFT with places > 0: load count = places, go to SHIFT.
    - SHIFT with places = 0: go directly to FINISH.
  - A start arriving exactly on the end of an odd M/C still spends one full pass in ARM, i.e. waits for the next odd end.
- MUL
  - c5 = 1 for every clock in this state.
  - At each end of M/C, count decrements.
  - At end of M/C with count = 1, go to FINISH.
  - c5 is therefore high for exactly MUL_DIGITS*PI_PER_MC clocks, beginning on an ev_d0 cycle.
- SHIFT
  - c6 = 1 throughout.
  - s2 = 1 on the d0 cycle of each shift M/C only.
  - Count decrement and exit follow the same rule as MUL.
  - Exit to FINISH may fall on either M/C parity.
- FINISH
  - c7 = 1 for exactly one full M/C (d0 through d35).
  - At its d35, go to IDLE.
  - done is registered and asserted on the first IDLE clock (the following d0). It lasts exactly 1 clock.
- busy = 1 in ARM, MUL, SHIFT and FINISH.
  - busy falls on the same clock done rises.
  - A new start is accepted on the done clock.

Invariants:
- c5, c6 and c7 are mutually exclusive.
- s2 never occurs outside SHIFT.
- The count is never underflowed.
- The p.i. counter and parity are never disturbed by orders.

Test Plan:
- Reset release, idle run -> d0 on clocks 0, 36, 72; d35 on clocks 35, 71; ev_d0 on clocks 0, 72 and not on 36; all control outputs 0.
- start_mul pulse at p.i. 5 of the even M/C starting at clock 0 -> ARM until clock 71; c5 high on clocks 72..683 (612 clocks); c7 high on 684..719; done = 1 only at 720; busy high 6..719.
- start_shift with shift_places = 3 at p.i. 10 of the even M/C starting at clock 0 -> c6 high on 72..179; s2 only on clocks 72, 108, 144; c7 on 180..215; done at 216.
- start_shift with shift_places = 0 -> no c6 and no s2; c7 for one M/C starting at the first ev_d0 after start; then done.
- start_mul and start_shift in the same clock, plus a new start_shift mid-multiply -> only the multiply runs, with identical timing to the plain start_mul test; the later request is ignored; c6 never rises.
- rst asserted during MUL at clock 300 -> on the next clock all outputs 0 and state IDLE; no done; after release the p.i. counter restarts at 0 and a fresh start_mul completes normally.
